bus_master: RTL and testbench

- Serial-bus master for the shared single-wire data bus.
- Accepts parallel requests from a local module (hold, execute, R/W, address, data).
- Arbitrates for the bus via request/grant, then shifts address and data bit-serially onto an open-drain line.
- Returns read data or completion status to the local module; addressed bus slaves sit on the same wires.

---
 rtl/bus_pkg.sv | 30 +++
 rtl/bus_serializer.sv | 51 +++++
 rtl/bus_master.sv | 226 ++++++++++++++++++++++
 tb/tb_bus_master.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and address helpers for the single-wire serial bus master.
package bus_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_REQUEST,
        ST_READY,
        ST_START,
        ST_ADDR,
        ST_ACK,
        ST_WDATA,
        ST_RWAIT,
        ST_RDATA,
        ST_DONE
    } bus_state_e;

    localparam logic START_BIT      = 1'b0;
    localparam int   SLAVE_ID_WIDTH = 2;

    // The slave ID lives in the top SLAVE_ID_WIDTH bits of an aw-bit address.
    function automatic logic [SLAVE_ID_WIDTH-1:0] addr_slave_id(input logic [31:0] addr,
                                                                input int unsigned aw);
        return addr[aw-1 -: SLAVE_ID_WIDTH];
    endfunction

    function automatic logic [31:0] addr_offset(input logic [31:0] addr, input int unsigned aw);
        return addr & ((32'd1 << (aw - SLAVE_ID_WIDTH)) - 32'd1);
    endfunction

endpackage

// File: rtl/bus_serializer.sv
// LSB-first shift register with a down-counting bit counter; transmits as
// open-drain (drive low or release) and receives into the top of the register.
module bus_serializer #(
    parameter int W          = 15,
    parameter int RX_W       = 8,
    parameter int BIT_LENGTH = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  load,
    input  logic [W-1:0]          load_data,
    input  logic [BIT_LENGTH-1:0] load_last,
    input  logic                  shift,
    input  logic                  tx_en,
    input  logic                  sin,
    output logic                  drive_low,
    output logic                  done,
    output logic [RX_W-1:0]       rx_word
);

    logic [W-1:0]          sr_q, sr_d;
    logic [BIT_LENGTH-1:0] cnt_q, cnt_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        if (load) begin
            sr_d  = load_data;
            cnt_d = load_last;
        end else if (shift) begin
            sr_d  = {sin, sr_q[W-1:1]};
            cnt_d = cnt_q - BIT_LENGTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign drive_low = tx_en & ~sr_q[0];
    assign done      = (cnt_q == '0);
    // Received word as it will stand once the bit on sin is shifted in.
    assign rx_word   = {sin, sr_q[W-1 -: RX_W-1]};

endmodule

// File: rtl/bus_master.sv
// Serial-bus master: request/grant arbitration, then start bit, address, ACK and
// data on an open-drain line. Optional ACK/RWAIT timeout: BUS_MASTER_TIMEOUT_EN.
module bus_master
    import bus_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDRS_WIDTH = 15,
`ifdef BUS_MASTER_TIMEOUT_EN
    parameter int TIMEOUT_LEN = 6,
`endif
    parameter int BIT_LENGTH  = 4
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   m_hold,
    input  logic                   m_execute,
    input  logic                   m_RW,
    input  logic [ADDRS_WIDTH-1:0] m_address,
    input  logic [DATA_WIDTH-1:0]  m_din,
    output logic [DATA_WIDTH-1:0]  m_dout,
    output logic                   m_dvalid,
    output logic                   m_master_bsy,
    input  logic                   b_grant,
    inout  wire                    b_BUS,
    output logic                   b_request,
    inout  wire                    b_RW,
    inout  wire                    b_bus_utilizing
);

    localparam int SER_W = (ADDRS_WIDTH > DATA_WIDTH) ? ADDRS_WIDTH : DATA_WIDTH;

    bus_state_e                state_q, state_d;
    logic                      rw_q, rw_d;
    logic [DATA_WIDTH-1:0]     din_q, din_d;
    logic [DATA_WIDTH-1:0]     dout_q, dout_d;
    logic                      dvalid_q, dvalid_d;
    logic                      bsy_q, bsy_d;
    logic                      req_q, req_d;

    logic                      ser_load, ser_shift, ser_tx, ser_drive_low, ser_done;
    logic [SER_W-1:0]          ser_load_data;
    logic [BIT_LENGTH-1:0]     ser_load_last;
    logic [DATA_WIDTH-1:0]     ser_rx_word;

    logic                      bus_in, timeout, in_xfer, grant_lost;

    assign bus_in     = b_BUS;
    assign in_xfer    = state_q inside {ST_START, ST_ADDR, ST_ACK, ST_WDATA,
                                        ST_RWAIT, ST_RDATA, ST_DONE};
    assign grant_lost = !b_grant && in_xfer && (state_q != ST_DONE);
    assign ser_tx     = state_q inside {ST_ADDR, ST_WDATA};

    bus_serializer #(
        .W          (SER_W),
        .RX_W       (DATA_WIDTH),
        .BIT_LENGTH (BIT_LENGTH)
    ) u_ser (
        .clk        (clk),
        .rstn       (rstn),
        .load       (ser_load),
        .load_data  (ser_load_data),
        .load_last  (ser_load_last),
        .shift      (ser_shift),
        .tx_en      (ser_tx),
        .sin        (bus_in),
        .drive_low  (ser_drive_low),
        .done       (ser_done),
        .rx_word    (ser_rx_word)
    );

    always_comb begin
        state_d       = state_q;
        rw_d          = rw_q;
        din_d         = din_q;
        dout_d        = dout_q;
        dvalid_d      = 1'b0;
        bsy_d         = bsy_q;
        req_d         = req_q;
        ser_load      = 1'b0;
        ser_shift     = 1'b0;
        ser_load_data = SER_W'(m_address);
        ser_load_last = BIT_LENGTH'(ADDRS_WIDTH - 1);

        case (state_q)
            ST_IDLE: begin
                if (m_hold) begin
                    state_d = ST_REQUEST;
                    req_d   = 1'b1;
                end
            end
            ST_REQUEST: begin
                if (b_grant) begin
                    state_d = ST_READY;
                    bsy_d   = 1'b0;
                end
            end
            ST_READY: begin
                if (!b_grant) begin
                    state_d = ST_REQUEST;
                    bsy_d   = 1'b1;
                end else if (!m_hold) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                    bsy_d   = 1'b1;
                end else if (m_execute) begin
                    rw_d     = m_RW;
                    din_d    = m_din;
                    ser_load = 1'b1;
                    state_d  = ST_START;
                    bsy_d    = 1'b1;
                end
            end
            ST_START: state_d = ST_ADDR;
            ST_ADDR: begin
                ser_shift = 1'b1;
                if (ser_done) state_d = ST_ACK;
            end
            ST_ACK: begin
                ser_load_data = SER_W'(din_q);
                ser_load_last = BIT_LENGTH'(DATA_WIDTH - 1);
                if (!bus_in) begin
                    ser_load = rw_q;
                    state_d  = rw_q ? ST_WDATA : ST_RWAIT;
                end else if (timeout) begin
                    state_d = ST_READY;
                    bsy_d   = 1'b0;
                end
            end
            ST_WDATA: begin
                ser_shift = 1'b1;
                if (ser_done) begin
                    state_d  = ST_DONE;
                    dvalid_d = 1'b1;
                end
            end
            ST_RWAIT: begin
                ser_load_last = BIT_LENGTH'(DATA_WIDTH - 1);
                if (bus_in == START_BIT) begin
                    ser_load = 1'b1;
                    state_d  = ST_RDATA;
                end else if (timeout) begin
                    state_d = ST_READY;
                    bsy_d   = 1'b0;
                end
            end
            ST_RDATA: begin
                ser_shift = 1'b1;
                if (ser_done) begin
                    state_d  = ST_DONE;
                    dvalid_d = 1'b1;
                    dout_d   = ser_rx_word;
                end
            end
            ST_DONE: begin
                if (m_hold) begin
                    state_d = ST_READY;
                    bsy_d   = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Losing the grant mid-transfer abandons it and re-arbitrates.
        if (grant_lost) begin
            state_d   = ST_REQUEST;
            bsy_d     = 1'b1;
            dvalid_d  = 1'b0;
            dout_d    = dout_q;
            ser_load  = 1'b0;
            ser_shift = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            state_q  <= ST_IDLE;
            rw_q     <= 1'b0;
            din_q    <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            bsy_q    <= 1'b1;
            req_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rw_q     <= rw_d;
            din_q    <= din_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            bsy_q    <= bsy_d;
            req_q    <= req_d;
        end
    end

`ifdef BUS_MASTER_TIMEOUT_EN
    logic [TIMEOUT_LEN-1:0] tmo_q, tmo_d;

    assign timeout = (tmo_q == '1);

    // Counts clocks spent in the current ACK/RWAIT visit; restarts on any move.
    always_comb begin
        tmo_d = '0;
        if ((state_q == ST_ACK || state_q == ST_RWAIT) && state_d == state_q)
            tmo_d = tmo_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) tmo_q <= '0;
        else      tmo_q <= tmo_d;
    end
`else
    assign timeout = 1'b0;
`endif

    assign b_BUS           = (state_q == ST_START || ser_drive_low) ? 1'b0 : 1'bz;
    assign b_bus_utilizing = in_xfer ? 1'b1 : 1'bz;
    assign b_RW            = (in_xfer && rw_q) ? 1'b1 : 1'bz;

    assign b_request    = req_q;
    assign m_dout       = dout_q;
    assign m_dvalid     = dvalid_q;
    assign m_master_bsy = bsy_q;

endmodule

// File: tb/tb_bus_master.sv
// Randomized scoreboard bench for bus_master with a behavioural bus slave.
module tb_bus_master;
    import bus_pkg::*;

    localparam int AW = 15;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          m_hold = 1'b0, m_execute = 1'b0, m_RW = 1'b0, b_grant = 1'b0;
    logic [AW-1:0] m_address = '0;
    logic [DW-1:0] m_din = '0;
    logic [DW-1:0] m_dout;
    logic          m_dvalid, m_master_bsy, b_request;
    logic          slv_low = 1'b0;

    wire b_bus_w, b_rw_w, b_util_w;
    pullup   (b_bus_w);
    pulldown (b_rw_w);
    pulldown (b_util_w);
    assign b_bus_w = slv_low ? 1'b0 : 1'bz;

    always #5 clk = ~clk;

    bus_master dut (
        .clk(clk), .rstn(rstn), .m_hold(m_hold), .m_execute(m_execute), .m_RW(m_RW),
        .m_address(m_address), .m_din(m_din), .m_dout(m_dout), .m_dvalid(m_dvalid),
        .m_master_bsy(m_master_bsy), .b_grant(b_grant), .b_BUS(b_bus_w),
        .b_request(b_request), .b_RW(b_rw_w), .b_bus_utilizing(b_util_w)
    );

    typedef struct {
        bit            is_wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] slv_mem [int];
    int            errors = 0;
    int            checks = 0;
    int            ack_dly = 0;
    int            rd_dly = 0;
    bit            bfm_done = 0;
    bit            bfm_rw = 0;
    logic [AW-1:0] bfm_addr = '0;
    logic [DW-1:0] bfm_wr_data = '0;
    logic [DW-1:0] last_rd = '0;

    function automatic logic [DW-1:0] init_val(input int a);
        return DW'(a) ^ 8'h5A;
    endfunction

    function automatic bit slave_present(input logic [AW-1:0] a);
        return addr_slave_id(32'(a), AW) != 2'b01;
    endfunction

    function automatic logic [DW-1:0] ref_read(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    function automatic logic [DW-1:0] slv_read(input int a);
        return slv_mem.exists(a) ? slv_mem[a] : init_val(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    // Slave on the shared wires: decodes start bit and address, ACKs, then
    // captures write data or returns read data LSB first after its own start bit.
    initial begin : slave_bfm
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            ok, wr;
        forever begin
            @(negedge clk);
            if (b_util_w === 1'b1 && b_bus_w === 1'b0 && rstn === 1'b0) begin
                ok = 1;
                wr = b_rw_w;
                for (int i = 0; i < AW; i++) begin
                    @(negedge clk);
                    if (b_util_w !== 1'b1) ok = 0;
                    a[i] = b_bus_w;
                end
                if (ok && slave_present(a)) begin
                    @(negedge clk);
                    repeat (ack_dly) @(negedge clk);
                    slv_low = 1'b1;
                    @(posedge clk);
                    #1 slv_low = 1'b0;
                    if (wr) begin
                        for (int i = 0; i < DW; i++) begin
                            @(negedge clk);
                            if (b_util_w !== 1'b1) ok = 0;
                            d[i] = b_bus_w;
                        end
                        if (ok) begin
                            slv_mem[int'(a)] = d;
                            bfm_wr_data = d;
                            bfm_addr = a;
                            bfm_rw = wr;
                            bfm_done = 1;
                        end
                    end else begin
                        d = slv_read(int'(a));
                        bfm_addr = a;
                        bfm_rw = wr;
                        bfm_done = 1;
                        repeat (rd_dly) begin
                            @(posedge clk);
                            #1;
                        end
                        slv_low = 1'b1;
                        @(posedge clk);
                        #1;
                        for (int i = 0; i < DW; i++) begin
                            slv_low = ~d[i];
                            @(posedge clk);
                            #1;
                        end
                        slv_low = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: every m_dvalid pulse must match the oldest outstanding expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (m_dvalid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_dvalid: got m_dvalid=1 required 0 (nothing outstanding)");
                end else begin
                    e = sb.pop_front();
                    check("slave_saw_txn", 32'(bfm_done), 32'd1);
                    check("slave_addr", 32'(bfm_addr), 32'(e.addr));
                    check("b_rw_line", 32'(bfm_rw), 32'(e.is_wr));
                    if (e.is_wr) check("write_capture", 32'(bfm_wr_data), 32'(e.data));
                    else         check("read_data", 32'(m_dout), 32'(e.data));
                    bfm_done = 0;
                end
            end
        end
    end

    task automatic wait_ready(input string tag, input int limit);
        int n = 0;
        while (m_master_bsy !== 1'b0 && n < limit) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, 32'(m_master_bsy), 32'd0);
    endtask

    task automatic issue(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] din);
        m_RW = wr;
        m_address = addr;
        m_din = din;
        m_execute = 1'b1;
        @(posedge clk);
        #1 m_execute = 1'b0;
    endtask

    task automatic do_txn(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] din);
        exp_t e;
        int   n;
        wait_ready("ready_before_txn", 200);
        if (slave_present(addr)) begin
            e.is_wr = wr;
            e.addr  = addr;
            e.data  = wr ? din : ref_read(int'(addr));
            if (wr) ref_mem[int'(addr)] = din;
            sb.push_back(e);
            issue(wr, addr, din);
            wait_ready("txn_complete", 300);
            if (!wr) last_rd = e.data;
        end else begin
            issue(wr, addr, din);
`ifdef BUS_MASTER_TIMEOUT_EN
            n = 0;
            while (m_master_bsy !== 1'b0 && n < 300) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("timeout_cycles", 32'(n), 32'(1 + AW + 64));
            check("timeout_util_released", 32'(b_util_w), 32'd0);
            check("timeout_dout_held", 32'(m_dout), 32'(last_rd));
`else
            n = 0;
            repeat (100) begin
                @(posedge clk);
                n++;
            end
            #1;
            check("no_slave_still_busy", 32'(m_master_bsy), 32'd1);
            check("no_slave_still_util", 32'(b_util_w), 32'd1);
            b_grant = 1'b0;
            @(posedge clk);
            #1;
            check("no_slave_abort_util", 32'(b_util_w), 32'd0);
            check("no_slave_abort_req", 32'(b_request), 32'd1);
            b_grant = 1'b1;
            wait_ready("no_slave_regrant", 20);
            check("no_slave_dout_held", 32'(m_dout), 32'(last_rd));
`endif
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [AW-1:0] pool [6];
        int            n;
        pool[0] = 15'h5555; pool[1] = 15'h0012; pool[2] = 15'h4ABC;
        pool[3] = 15'h7FFF; pool[4] = 15'h0000; pool[5] = 15'h6001;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_b_request", 32'(b_request), 32'd0);
        check("rst_m_dvalid", 32'(m_dvalid), 32'd0);
        check("rst_m_dout", 32'(m_dout), 32'd0);
        check("rst_m_master_bsy", 32'(m_master_bsy), 32'd1);
        check("rst_b_bus_released", 32'(b_bus_w), 32'd1);
        check("rst_b_util_released", 32'(b_util_w), 32'd0);
        check("rst_b_rw_released", 32'(b_rw_w), 32'd0);
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_no_request", 32'(b_request), 32'd0);

        // Arbitration handshake
        m_hold = 1'b1;
        n = 0;
        while (b_request !== 1'b1 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("request_raised", 32'(b_request), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("no_grant_busy", 32'(m_master_bsy), 32'd1);
        b_grant = 1'b1;
        wait_ready("granted_ready", 10);

        // Directed write then read of the same location
        do_txn(1'b1, 15'd21845, 8'd203);
        slv_mem[21845] = 8'd178;
        ref_mem[21845] = 8'd178;
        do_txn(1'b0, 15'd21845, 8'd0);

        // Absent slave (ID 2'b01)
        do_txn(1'b0, 15'h2ABC, 8'd0);
        do_txn(1'b1, 15'h3001, 8'h77);

        // Randomized traffic
        for (int i = 0; i < 24; i++) begin
            ack_dly = int'($urandom_range(0, 3));
            rd_dly  = int'($urandom_range(0, 3));
            do_txn(1'($urandom_range(0, 1)), pool[$urandom_range(0, 5)], 8'($urandom));
        end
        ack_dly = 0;
        rd_dly  = 0;

        // Grant withdrawn mid-ADDR
        wait_ready("ready_before_abort", 200);
        issue(1'b1, 15'h5555, 8'h3C);
        repeat (4) @(posedge clk);
        #1;
        check("abort_util_before", 32'(b_util_w), 32'd1);
        b_grant = 1'b0;
        @(posedge clk);
        #1;
        check("abort_util_released", 32'(b_util_w), 32'd0);
        check("abort_bus_released", 32'(b_bus_w), 32'd1);
        check("abort_rw_released", 32'(b_rw_w), 32'd0);
        check("abort_request_held", 32'(b_request), 32'd1);
        check("abort_busy", 32'(m_master_bsy), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        b_grant = 1'b1;
        wait_ready("abort_regrant", 10);

        // Hold dropped in READY
        m_hold = 1'b0;
        @(posedge clk);
        #1;
        check("unhold_request_low", 32'(b_request), 32'd0);
        check("unhold_busy", 32'(m_master_bsy), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        check("unhold_stays_idle", 32'(b_request), 32'd0);
        m_hold = 1'b1;
        wait_ready("rehold_ready", 10);

        // Reset asserted in the middle of WDATA
        issue(1'b1, 15'd21845, 8'hE1);
        repeat (19) @(posedge clk);
        @(negedge clk);
        check("wdata_util_driven", 32'(b_util_w), 32'd1);
        check("wdata_rw_driven", 32'(b_rw_w), 32'd1);
        rstn = 1'b1;
        #1;
        check("rst_mid_util", 32'(b_util_w), 32'd0);
        check("rst_mid_bus", 32'(b_bus_w), 32'd1);
        check("rst_mid_rw", 32'(b_rw_w), 32'd0);
        check("rst_mid_request", 32'(b_request), 32'd0);
        check("rst_mid_busy", 32'(m_master_bsy), 32'd1);
        check("rst_mid_dvalid", 32'(m_dvalid), 32'd0);
        repeat (4) @(posedge clk);
        #1;
        rstn = 1'b0;
        wait_ready("post_reset_ready", 20);
        do_txn(1'b0, 15'd21845, 8'd0);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
